// File: rtl/dec_lut_pkg.sv
// dec_lut_pkg: shared parameters, FSM state type and helpers for the
// 16-bit LUT codec (encoder side and decoder LUT contents).
//   N_BITS : message index width
//   W_BITS : arithmetic codeword width
//   GEN    : odd generator constant; W = N * GEN
//   CNT_W  : width of the shift-add step counter
package dec_lut_pkg;

  localparam int unsigned N_BITS = 17;
  localparam int unsigned W_BITS = 30;
  localparam int unsigned GEN    = 8191;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned CNT_W = cnt_width(N_BITS);

endpackage

// File: rtl/dec_lut_shift_add.sv
// dec_lut_shift_add: serial shift-add datapath computing n_i * GEN.
//   clk_i      : clock, rising edge
//   rst_i      : synchronous active-high reset, clears all registers
//   load_i     : mcand <= GEN, mult <= n_i, acc <= 0
//   step_i     : acc <= acc_next, mcand <<= 1, mult >>= 1
//   n_i        : multiplier (message index)
//   acc_next_o : accumulator value after the current step
//   mult_o     : remaining multiplier bits
module dec_lut_shift_add #(
  parameter int unsigned N_BITS = dec_lut_pkg::N_BITS,
  parameter int unsigned W_BITS = dec_lut_pkg::W_BITS,
  parameter int unsigned GEN    = dec_lut_pkg::GEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [N_BITS-1:0] n_i,
  output logic [W_BITS-1:0] acc_next_o,
  output logic [N_BITS-1:0] mult_o
);

  logic [W_BITS-1:0] mcand_q;
  logic [N_BITS-1:0] mult_q;
  logic [W_BITS-1:0] acc_q;

  always_comb begin
    acc_next_o = acc_q + (mult_q[0] ? mcand_q : '0);
    mult_o     = mult_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mcand_q <= '0;
      mult_q  <= '0;
      acc_q   <= '0;
    end else if (load_i) begin
      mcand_q <= W_BITS'(GEN);
      mult_q  <= n_i;
      acc_q   <= '0;
    end else if (step_i) begin
      acc_q   <= acc_next_o;
      mcand_q <= {mcand_q[W_BITS-2:0], 1'b0};
      mult_q  <= {1'b0, mult_q[N_BITS-1:1]};
    end
  end

endmodule

// File: rtl/dec_lut_encoder16_clk.sv
// dec_lut_encoder16_clk: encoder for the 16-bit LUT decoder. Computes the
// codeword W = N * GEN with a serial shift-add multiplier and a start/done
// handshake matching the decoder's timing.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; aborts an encode without done
//   start : request, accepted only in IDLE or DONE
//   N     : message index, captured on the accepted start edge
//   busy  : high while multiplying
//   done  : one-cycle pulse; W valid from this cycle
//   W     : codeword, held until the next done
// Build option: DEC_LUT_ENC_ZSKIP_EN enables early termination once the
// remaining multiplier bits are zero (N==0 goes straight to DONE).
module dec_lut_encoder16_clk #(
  parameter int unsigned N_BITS = dec_lut_pkg::N_BITS,
  parameter int unsigned W_BITS = dec_lut_pkg::W_BITS,
  parameter int unsigned GEN    = dec_lut_pkg::GEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N_BITS-1:0] N,
  output logic              busy,
  output logic              done,
  output logic [W_BITS-1:0] W
);

  import dec_lut_pkg::*;

  if (W_BITS < N_BITS + $clog2(GEN + 1)) begin : g_bad_width
    $error("dec_lut_encoder16_clk: W_BITS too small for N_BITS and GEN");
  end
  if ((GEN % 2) == 0) begin : g_bad_gen
    $error("dec_lut_encoder16_clk: GEN must be odd");
  end

  localparam int unsigned CW = cnt_width(N_BITS);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_BITS - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [W_BITS-1:0] w_q, w_d;
  logic              load, step, last;
  logic [W_BITS-1:0] acc_next;
  logic [N_BITS-1:0] mult;

  dec_lut_shift_add #(
    .N_BITS(N_BITS),
    .W_BITS(W_BITS),
    .GEN   (GEN)
  ) u_mul (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (load),
    .step_i    (step),
    .n_i       (N),
    .acc_next_o(acc_next),
    .mult_o    (mult)
  );

`ifdef DEC_LUT_ENC_ZSKIP_EN
  // Exit as soon as no set multiplier bits remain beyond the current one.
  assign last = (cnt_q == CNT_LAST) || (mult[N_BITS-1:1] == '0);
`else
  assign last = (cnt_q == CNT_LAST);
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    w_d     = w_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (start) begin
`ifdef DEC_LUT_ENC_ZSKIP_EN
          if (N == '0) begin
            state_d = DONE;
            w_d     = '0;
          end else begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = MUL;
          end
`else
          load    = 1'b1;
          cnt_d   = '0;
          state_d = MUL;
`endif
        end
      end
      MUL: begin
        step  = 1'b1;
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          w_d     = acc_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      w_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      w_q     <= w_d;
    end
  end

  assign busy = (state_q == MUL);
  assign done = (state_q == DONE);
  assign W    = w_q;

endmodule

// File: tb/tb_dec_lut_encoder16_clk.sv
// Testbench for dec_lut_encoder16_clk: directed encodes with hand-computed
// codewords; expected results are queued at issue time and checked by an
// independent monitor whenever done pulses.
module tb_dec_lut_encoder16_clk;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [16:0] N;
  logic        busy;
  logic        done;
  logic [29:0] W;

  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  typedef struct {
    logic [29:0] w;
    int unsigned lat;
    int unsigned c0;
    logic [16:0] n;
  } exp_t;

  exp_t sb[$];

  dec_lut_encoder16_clk #(
    .N_BITS(17),
    .W_BITS(30),
    .GEN   (8191)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .N    (N),
    .busy (busy),
    .done (done),
    .W    (W)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned exp_lat(input logic [16:0] n);
`ifdef DEC_LUT_ENC_ZSKIP_EN
    int unsigned h = 0;
    if (n == '0) return 1;
    for (int i = 0; i < 17; i++) if (n[i]) h = i;
    return h + 2;
`else
    return 18;
`endif
  endfunction

  // Monitor: compare each done pulse against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      if (busy && done) check("busy_done_overlap", 1, 0);
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          logic found;
          longint dec_n;
          e = sb.pop_front();
          check("W", W, e.w);
          check("latency", cyc - e.c0 + 1, e.lat);
          // Decoder model: W must be a multiple of GEN with quotient in range.
          found = ((W % 30'd8191) == 0) && ((W / 30'd8191) < 131072);
          dec_n = found ? longint'(W / 30'd8191) : -1;
          check("loopback_found", found, 1);
          check("loopback_N", dec_n, e.n);
        end
      end
    end
  end

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() > 0; i++) @(posedge clk);
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Drive one accepted start; returns just after the accepting edge.
  task automatic issue(input logic [16:0] n, input logic [29:0] w);
    exp_t e;
    @(posedge clk);
    #2;
    start = 1'b1;
    N     = n;
    e.w = w; e.lat = exp_lat(n); e.c0 = cyc + 1; e.n = n;
    sb.push_back(e);
    @(posedge clk);
    #2;
    start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned bcnt;
    int unsigned gap;
    exp_t e;
    int unsigned c;

    rst = 1'b1; start = 1'b0; N = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_W", W, 0);
    #1 rst = 1'b0;

    // 1: N=65535, count busy cycles
    issue(17'd65535, 30'd536797185);
    bcnt = busy ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done) break;
      if (busy) bcnt++;
    end
    check("busy_cycles", bcnt, exp_lat(17'd65535) - 1);
    wait_drain();

    // 2, 3: zero, one, max
    issue(17'd0, 30'd0);
    wait_drain();
    issue(17'd1, 30'd8191);
    wait_drain();
    issue(17'd131071, 30'd1073602561);
    wait_drain();

    // 4: second start during MUL is dropped
`ifdef DEC_LUT_ENC_ZSKIP_EN
    gap = 1;
`else
    gap = 4;
`endif
    issue(17'd5, 30'd40955);
    repeat (gap) @(posedge clk);
    #2;
    start = 1'b1;
    N     = 17'd7;
    check("busy_at_drop", busy, 1);
    @(posedge clk);
    #2;
    start = 1'b0;
    wait_drain();

    // 5: reset mid-encode aborts without done
    issue(17'd70000, 30'd573370000);
    repeat (8) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_W", W, 0);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    issue(17'd2, 30'd16382);
    wait_drain();

    // 6: back-to-back with start held high
    @(posedge clk);
    #2;
    start = 1'b1;
    N     = 17'd3;
    c = cyc + 1;
    e.w = 30'd24573; e.lat = exp_lat(17'd3); e.c0 = c; e.n = 17'd3;
    sb.push_back(e);
    e.w = 30'd32764; e.lat = exp_lat(17'd4); e.c0 = c + exp_lat(17'd3); e.n = 17'd4;
    sb.push_back(e);
    @(posedge clk);
    #2;
    N = 17'd4;
    repeat (exp_lat(17'd3)) @(posedge clk);
    #2;
    start = 1'b0;
    wait_drain();

    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
